// File: rtl/hdlc_mon_pkg.sv
// Shared types and helpers for the HDLC receive-side protocol monitor.
package hdlc_mon_pkg;

  localparam int NUM_RULES = 3;
  localparam logic [7:0] FLAG_PATTERN = 8'h7E;

  typedef enum logic [1:0] {
    RULE_FLAG   = 2'd0,
    RULE_ABORT  = 2'd1,
    RULE_STATUS = 2'd2
  } rule_e;

  // Callers zero-extend into 64 bits and truncate the result back to their width.
  function automatic logic [63:0] sat_add(input logic [63:0] a, input logic [63:0] b,
                                          input logic [63:0] max_v);
    logic [64:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    return (sum > {1'b0, max_v}) ? max_v : sum[63:0];
  endfunction

endpackage

// File: rtl/hdlc_mon_delay_line.sv
// Single-bit expectation shift register of DEPTH stages with synchronous reset.
module hdlc_mon_delay_line #(
  parameter int DEPTH = 2
) (
  input  logic Clk,
  input  logic Rst,
  input  logic i_d,
  output logic o_q
);

  logic [DEPTH-1:0] r_sr;

  generate
    if (DEPTH == 1) begin : g_single
      always_ff @(posedge Clk) begin
        if (Rst) r_sr <= '0;
        else     r_sr <= i_d;
      end
    end else begin : g_multi
      always_ff @(posedge Clk) begin
        if (Rst) r_sr <= '0;
        else     r_sr <= {r_sr[DEPTH-2:0], i_d};
      end
    end
  endgenerate

  assign o_q = r_sr[DEPTH-1];

endmodule

// File: rtl/hdlc_rx_protocol_monitor.sv
// Run-time checker for HDLC Rx flag latency, abort latency and end-of-frame status.
// Optional first-error cycle stamp enabled by defining HDLC_MON_TIMESTAMP_EN.
module hdlc_rx_protocol_monitor
  import hdlc_mon_pkg::*;
#(
  parameter int FLAG_LAT  = 2,
  parameter int ABORT_LAT = 1,
  parameter int CNT_W     = 16,
  parameter int TS_W      = 32
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic              Rx,
  input  logic              Rx_FlagDetect,
  input  logic              Rx_AbortDetect,
  input  logic              Rx_ValidFrame,
  input  logic              Rx_AbortSignal,
  input  logic              Rx_EoF,
  input  logic              Rx_Overflow,
  input  logic              Rx_FrameError,
  input  logic              Rx_Ready,
  input  logic              Clr_Err,
  output logic [2:0]        Err_Sticky,
  output logic [CNT_W-1:0]  ErrCnt,
  output logic              First_Err_Valid,
  output logic [1:0]        First_Err_Id,
  output logic [TS_W-1:0]   First_Err_Time
);

  localparam logic [63:0] CNT_MAX = (64'd1 << CNT_W) - 64'd1;

  logic [6:0]           r_hist;
  logic                 r_eof_prev;
  logic [CNT_W-1:0]     r_cnt;
  logic [NUM_RULES-1:0] r_sticky;
  logic                 r_fvalid;
  rule_e                r_fid;

  logic                 w_match;
  logic                 w_abort_push;
  logic                 w_flag_tap;
  logic                 w_abort_tap;
  logic                 w_eof_rise;
  logic [2:0]           w_status_ones;
  logic [NUM_RULES-1:0] w_viol;
  logic [1:0]           w_nviol;
  rule_e                w_first_id;
  logic [CNT_W-1:0]     w_cnt_base;
  logic [NUM_RULES-1:0] w_sticky_base;
  logic                 w_fvalid_base;
  logic                 w_capture;
  logic [CNT_W-1:0]     w_cnt_nxt;

  hdlc_mon_delay_line #(.DEPTH(FLAG_LAT)) u_flag_dl (
    .Clk (Clk),
    .Rst (Rst),
    .i_d (w_match),
    .o_q (w_flag_tap)
  );

  hdlc_mon_delay_line #(.DEPTH(ABORT_LAT)) u_abort_dl (
    .Clk (Clk),
    .Rst (Rst),
    .i_d (w_abort_push),
    .o_q (w_abort_tap)
  );

  always_comb begin
    w_match       = ({r_hist, Rx} == FLAG_PATTERN);
    w_abort_push  = Rx_AbortDetect && Rx_ValidFrame;
    w_eof_rise    = Rx_EoF && !r_eof_prev;
    w_status_ones = 3'({2'b00, Rx_AbortSignal}) + 3'({2'b00, Rx_Overflow})
                  + 3'({2'b00, Rx_FrameError})  + 3'({2'b00, Rx_Ready});
    w_viol        = {w_eof_rise && (w_status_ones != 3'd1),
                     w_abort_tap && !Rx_AbortSignal,
                     w_flag_tap != Rx_FlagDetect};
    w_nviol       = 2'({1'b0, w_viol[0]}) + 2'({1'b0, w_viol[1]}) + 2'({1'b0, w_viol[2]});
    w_first_id    = w_viol[0] ? RULE_FLAG : (w_viol[1] ? RULE_ABORT : RULE_STATUS);
  end

  // Clear takes effect first; this cycle's violations land on the cleared state.
  always_comb begin
    w_cnt_base    = Clr_Err ? '0 : r_cnt;
    w_sticky_base = Clr_Err ? '0 : r_sticky;
    w_fvalid_base = Clr_Err ? 1'b0 : r_fvalid;
    w_capture     = !w_fvalid_base && (w_nviol != 2'd0);
    w_cnt_nxt     = CNT_W'(sat_add(64'(w_cnt_base), 64'(w_nviol), CNT_MAX));
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      r_hist     <= 7'h7F;
      r_eof_prev <= 1'b0;
      r_cnt      <= '0;
      r_sticky   <= '0;
      r_fvalid   <= 1'b0;
      r_fid      <= RULE_FLAG;
    end else begin
      r_hist     <= {r_hist[5:0], Rx};
      r_eof_prev <= Rx_EoF;
      r_cnt      <= w_cnt_nxt;
      r_sticky   <= w_sticky_base | w_viol;
      r_fvalid   <= w_fvalid_base || w_capture;
      if (w_capture)    r_fid <= w_first_id;
      else if (Clr_Err) r_fid <= RULE_FLAG;
    end
  end

  assign Err_Sticky      = r_sticky;
  assign ErrCnt          = r_cnt;
  assign First_Err_Valid = r_fvalid;
  assign First_Err_Id    = r_fid;

`ifdef HDLC_MON_TIMESTAMP_EN
  logic [TS_W-1:0] r_ts;
  logic [TS_W-1:0] r_ftime;

  // The cycle counter free-runs across Clr_Err; only reset restarts it.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      r_ts    <= '0;
      r_ftime <= '0;
    end else begin
      r_ts <= r_ts + TS_W'(1);
      if (w_capture)    r_ftime <= r_ts;
      else if (Clr_Err) r_ftime <= '0;
    end
  end

  assign First_Err_Time = r_ftime;
`else
  assign First_Err_Time = '0;
`endif

endmodule
